// File: rtl/tau_cfg_pkg.sv
// Shared configuration constants for the tau datapath blocks.
package TauCfg;
    localparam int DIM     = 2;
    localparam int WORK_BW = 16;
endpackage

// File: rtl/block_dispatcher_if.sv
// Configuration, block-issue and completion signals of the block dispatcher.
interface block_dispatcher_if #(
    parameter int DIM = TauCfg::DIM,
    parameter int WBW = TauCfg::WORK_BW
);
    logic                     cfg_rdy;
    logic                     cfg_ack;
    logic [DIM-1:0][WBW-1:0]  i_bgrid_step;
    logic [DIM-1:0][WBW-1:0]  i_bgrid_end;
    logic                     blk_rdy;
    logic                     blk_ack;
    logic [DIM-1:0][WBW-1:0]  o_bofs;
    logic                     blkdone_dval;
    logic                     done_dval;
    logic                     o_err;

    modport slave (
        input  cfg_rdy, i_bgrid_step, i_bgrid_end, blk_ack, blkdone_dval,
        output cfg_ack, blk_rdy, o_bofs, done_dval, o_err
    );

    modport master (
        output cfg_rdy, i_bgrid_step, i_bgrid_end, blk_ack, blkdone_dval,
        input  cfg_ack, blk_rdy, o_bofs, done_dval, o_err
    );
endinterface

// File: rtl/block_dispatcher.sv
// Walks a block grid odometer-style, issuing offsets under an outstanding-block
// credit limit and signalling completion once every issued block has retired.
module block_dispatcher #(
    parameter int DIM     = TauCfg::DIM,
    parameter int WBW     = TauCfg::WORK_BW,
    parameter int N_OUTST = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    block_dispatcher_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [3:0] MAX_OUT = 4'(N_OUTST);

    state_t                   state_q, state_d;
    logic [DIM-1:0][WBW-1:0]  step_q, end_q;
    logic [DIM-1:0][WBW-1:0]  bofs_q, bofs_d, bofs_adv;
    logic [3:0]               cnt_q, cnt_d;
    logic                     blk_rdy_q, blk_rdy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     fire, cfg_fire, last_blk;
    logic [WBW:0]             sum;

    assign fire     = blk_rdy_q & bus.blk_ack;
    assign cfg_fire = (state_q == IDLE) & bus.cfg_rdy;

    // Odometer step: the innermost dimension is DIM-1; a carry out of dim 0 marks the last block.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        bofs_adv = bofs_q;
        last_blk = 1'b1;
        sum      = '0;
        for (int i = DIM - 1; i >= 0; i--) begin
            if (last_blk) begin
                sum = {1'b0, bofs_q[i]} + {1'b0, step_q[i]};
                if (sum <= {1'b0, end_q[i]}) begin
                    bofs_adv[i] = sum[WBW-1:0];
                    last_blk    = 1'b0;
                end else begin
                    bofs_adv[i] = '0;
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (fire && !bus.blkdone_dval) begin
            cnt_d = cnt_q + 4'd1;
        end else if (!fire && bus.blkdone_dval) begin
            if (cnt_q == 4'd0) err_d = 1'b1;
            else               cnt_d = cnt_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        bofs_d  = bofs_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_fire) begin
                    bofs_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fire) begin
                    bofs_d = bofs_adv;
                    if (last_blk) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_d == 4'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        blk_rdy_d = (state_d == ISSUE) && (cnt_d < MAX_OUT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            bofs_q    <= '0;
            cnt_q     <= '0;
            blk_rdy_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bofs_q    <= bofs_d;
            cnt_q     <= cnt_d;
            blk_rdy_q <= blk_rdy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // NOTE: grid bounds are pure data captured on every accepted config, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (cfg_fire) begin
            step_q <= bus.i_bgrid_step;
            end_q  <= bus.i_bgrid_end;
        end
    end

    assign bus.cfg_ack   = cfg_fire;
    assign bus.blk_rdy   = blk_rdy_q;
    assign bus.o_bofs    = bofs_q;
    assign bus.done_dval = done_q;
    assign bus.o_err     = err_q;

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed checks of block_dispatcher: credit table on a 2-credit instance,
// grid walks, reset and error handling on a 4-credit instance.
module tb_block_dispatcher;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    block_dispatcher_if #(.DIM(2), .WBW(16)) ia ();
    block_dispatcher_if #(.DIM(2), .WBW(16)) ib ();

    block_dispatcher #(.DIM(2), .WBW(16), .N_OUTST(4)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ia));
    block_dispatcher #(.DIM(2), .WBW(16), .N_OUTST(2)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ib));

    typedef struct packed {
        logic        cr, ak, bd, ca, rd;
        logic [15:0] b1;
    } vec_t;

    typedef struct packed {
        logic [15:0] d0, d1;
    } ofs_t;

    vec_t vb[14];
    ofs_t exp_q[$];

    function automatic vec_t mk(input logic [4:0] ctl, input int b1);
        mk = {ctl, 16'(b1)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic configure_a(input logic [15:0] s0, s1, e0, e1);
        @(negedge clk);
        ia.i_bgrid_step = {s1, s0};
        ia.i_bgrid_end  = {e1, e0};
        ia.cfg_rdy      = 1'b1;
        #1 check("cfg_ack", 32'(ia.cfg_ack), 32'd1);
        @(posedge clk);
        #1 ia.cfg_rdy = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        ia.blk_ack = 1'b0; ia.blkdone_dval = 1'b0; ia.cfg_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Always-ack sink with blkdone 3 cycles after each ack; compares offsets against exp_q.
    task automatic run_grid(input string name, input int stop_after);
        int pend[$];
        int cyc = 0, n_acks = 0, dones = 0, last_bd = -1, done_cyc = -1;
        bit stopped = 0;
        while (cyc < 200 && !(dones > 0 && cyc >= done_cyc + 4) && !stopped) begin
            @(negedge clk);
            cyc++;
            ia.blk_ack      = 1'b1;
            ia.blkdone_dval = 1'b0;
            if (pend.size() > 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                ia.blkdone_dval = 1'b1;
                last_bd = cyc;
            end
            #1;
            if (ia.done_dval) begin
                dones++;
                done_cyc = cyc;
            end
            if (ia.blk_rdy) begin
                if (n_acks < exp_q.size())
                    check({name, "_bofs"}, {ia.o_bofs[0], ia.o_bofs[1]},
                          {exp_q[n_acks].d0, exp_q[n_acks].d1});
                else
                    check({name, "_extra_block"}, 32'(n_acks), 32'(exp_q.size()));
                n_acks++;
                pend.push_back(cyc + 3);
                if (stop_after > 0 && n_acks == stop_after) stopped = 1;
            end
        end
        if (stop_after > 0) begin
            check({name, "_acks_before_stop"}, 32'(n_acks), 32'(stop_after));
        end else begin
            ia.blk_ack = 1'b0;
            ia.blkdone_dval = 1'b0;
            check({name, "_blocks"}, 32'(n_acks), 32'(exp_q.size()));
            check({name, "_done_pulses"}, 32'(dones), 32'd1);
            check({name, "_done_after_last_blkdone"}, 32'(done_cyc > last_bd), 32'd1);
        end
    endtask

    initial begin
        logic [6:0] ack_p, bd_p, rdy_p;

        ia.cfg_rdy = 0; ia.blk_ack = 0; ia.blkdone_dval = 0;
        ia.i_bgrid_step = '0; ia.i_bgrid_end = '0;
        ib.cfg_rdy = 0; ib.blk_ack = 0; ib.blkdone_dval = 0;
        ib.i_bgrid_step = {16'd1, 16'd1};
        ib.i_bgrid_end  = {16'd9, 16'd9};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_blk_rdy", 32'(ia.blk_rdy), 32'd0);
        check("rst_done", 32'(ia.done_dval), 32'd0);
        check("rst_err", 32'(ia.o_err), 32'd0);
        check("rst_bofs", {ia.o_bofs[0], ia.o_bofs[1]}, 32'd0);
        check("rst_cfg_ack", 32'(ia.cfg_ack), 32'd0);

        // Credit limit 2: {cfg_rdy, ack, blkdone, exp cfg_ack, exp blk_rdy}, exp inner offset
        vb[0]  = mk(5'b10010, 0);
        vb[1]  = mk(5'b01001, 0);
        vb[2]  = mk(5'b01001, 1);
        vb[3]  = mk(5'b01000, 2);
        vb[4]  = mk(5'b01000, 2);
        vb[5]  = mk(5'b11000, 2);
        vb[6]  = mk(5'b00100, 2);
        vb[7]  = mk(5'b01001, 2);
        vb[8]  = mk(5'b00000, 3);
        vb[9]  = mk(5'b00100, 3);
        vb[10] = mk(5'b01101, 3);
        vb[11] = mk(5'b00001, 4);
        vb[12] = mk(5'b01001, 4);
        vb[13] = mk(5'b00000, 5);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ib.cfg_rdy      = vb[i].cr;
            ib.blk_ack      = vb[i].ak;
            ib.blkdone_dval = vb[i].bd;
            #1;
            check($sformatf("credit_cfg_ack[%0d]", i), 32'(ib.cfg_ack), 32'(vb[i].ca));
            check($sformatf("credit_blk_rdy[%0d]", i), 32'(ib.blk_rdy), 32'(vb[i].rd));
            check($sformatf("credit_bofs[%0d]", i), {ib.o_bofs[0], ib.o_bofs[1]}, {16'd0, vb[i].b1});
            check($sformatf("credit_err[%0d]", i), 32'(ib.o_err), 32'd0);
        end
        @(negedge clk);
        ib.cfg_rdy = 0; ib.blk_ack = 0; ib.blkdone_dval = 0;

        // Same-cycle ack and blkdone at count 2 keeps the count at 2
        configure_a(16'd1, 16'd1, 16'd9, 16'd9);
        ack_p = 7'b0110111;
        bd_p  = 7'b0000100;
        rdy_p = 7'b0111111;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ia.blk_ack      = ack_p[i];
            ia.blkdone_dval = bd_p[i];
            #1 check($sformatf("same_cycle_blk_rdy[%0d]", i), 32'(ia.blk_rdy), 32'(rdy_p[i]));
        end
        pulse_reset();

        // 2x3 grid walk
        exp_q = '{'{16'd0, 16'd0}, '{16'd0, 16'd4}, '{16'd0, 16'd8},
                  '{16'd2, 16'd0}, '{16'd2, 16'd4}, '{16'd2, 16'd8}};
        configure_a(16'd2, 16'd4, 16'd2, 16'd8);
        run_grid("grid6", 0);

        // All ends below steps: a single block
        exp_q = '{'{16'd0, 16'd0}};
        configure_a(16'd4, 16'd4, 16'd1, 16'd1);
        run_grid("single", 0);

        // Reset after the third ack, then restart
        exp_q = '{'{16'd0, 16'd0}, '{16'd0, 16'd4}, '{16'd0, 16'd8},
                  '{16'd2, 16'd0}, '{16'd2, 16'd4}, '{16'd2, 16'd8}};
        configure_a(16'd2, 16'd4, 16'd2, 16'd8);
        run_grid("pre_reset", 3);
        @(negedge clk);
        rst = 1'b1;
        ia.blk_ack = 1'b0; ia.blkdone_dval = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_blk_rdy", 32'(ia.blk_rdy), 32'd0);
        check("midrst_bofs", {ia.o_bofs[0], ia.o_bofs[1]}, 32'd0);
        check("midrst_done", 32'(ia.done_dval), 32'd0);
        rst = 1'b0;
        configure_a(16'd2, 16'd4, 16'd2, 16'd8);
        run_grid("restart", 0);

        // Spurious blkdone in IDLE is sticky and leaves the count at 0
        @(negedge clk);
        ia.blkdone_dval = 1'b1;
        @(negedge clk);
        ia.blkdone_dval = 1'b0;
        #1;
        check("spurious_err", 32'(ia.o_err), 32'd1);
        check("spurious_blk_rdy", 32'(ia.blk_rdy), 32'd0);
        exp_q = '{'{16'd0, 16'd0}};
        configure_a(16'd4, 16'd4, 16'd1, 16'd1);
        run_grid("after_err", 0);
        #1 check("err_sticky", 32'(ia.o_err), 32'd1);
        pulse_reset();
        #1 check("err_cleared", 32'(ia.o_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
